// File: rtl/logo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : logo_pkg
// Description : Shared screen geometry and controller state encoding for the
//               bouncing-logo motion sequencer.
// Revision    : 1.0
// ============================================================================
package logo_pkg;

    localparam int c_LOGO_SIZE      = 128;
    localparam int c_DISPLAY_WIDTH  = 640;
    localparam int c_DISPLAY_HEIGHT = 480;

    // Largest origin that keeps the whole logo on screen along one axis.
    function automatic logic [9:0] max_origin(input int extent, input int size);
        return 10'(extent - size);
    endfunction

    localparam logic [9:0] c_MAX_LEFT = max_origin(c_DISPLAY_WIDTH, c_LOGO_SIZE);
    localparam logic [9:0] c_MAX_TOP  = max_origin(c_DISPLAY_HEIGHT, c_LOGO_SIZE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/logo_bounce_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : logo_bounce_controller_if
// Description : Sync-position inputs and logo position/colour outputs of the
//               logo motion sequencer.
// Revision    : 1.0
// ============================================================================
interface logo_bounce_controller_if;
    import logo_pkg::*;

    logic [9:0] vpos;
    logic [1:0] speed;
    logic       pause;
    logic [9:0] logo_left;
    logic [9:0] logo_top;
    logic       dir_x;
    logic       dir_y;
    logic [2:0] color;
    logic       busy;
    logic       bounce;
    logic       corner;

    modport master (
        output vpos, speed, pause,
        input  logo_left, logo_top, dir_x, dir_y, color, busy, bounce, corner
    );

    modport slave (
        input  vpos, speed, pause,
        output logo_left, logo_top, dir_x, dir_y, color, busy, bounce, corner
    );

endinterface
`default_nettype wire

// File: rtl/logo_bounce_controller_bounce_axis.sv
`default_nettype none
// ============================================================================
// Module      : bounce_axis
// Description : One-pixel-per-step position register for a single axis with
//               border reversal and a direction-flip indication.
// Revision    : 1.0
// ============================================================================
module bounce_axis
    import logo_pkg::*;
#(
    parameter logic [9:0] MAX      = 10'd512,
    parameter logic [9:0] INIT_POS = 10'd200,
    parameter logic       INIT_DIR = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_step_en,
    output logic      [9:0] o_pos,
    output logic            o_dir,
    output logic            o_flip
);

    logic [9:0] r_pos;
    logic       r_dir;
    logic [9:0] w_next_pos;
    logic       w_next_dir;

    assign w_next_pos = r_dir ? (r_pos + 10'd1) : (r_pos - 10'd1);

    // Direction is decided on the pixel just reached, so the logo stops
    // exactly on the border rather than overshooting it.
    assign w_next_dir = (w_next_pos == 10'd0) ? 1'b1 :
                        (w_next_pos == MAX)   ? 1'b0 : r_dir;

    assign o_flip = i_step_en && (w_next_dir != r_dir);
    assign o_pos  = r_pos;
    assign o_dir  = r_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= INIT_POS;
            r_dir <= INIT_DIR;
        end else if (i_step_en) begin
            r_pos <= w_next_pos;
            r_dir <= w_next_dir;
        end
    end

endmodule
`default_nettype wire

// File: rtl/logo_bounce_controller.sv
`default_nettype none
// ============================================================================
// Module      : logo_bounce_controller
// Description : Once-per-frame logo motion sequencer: moves the logo origin
//               speed+1 pixels at vertical blanking, bouncing at the borders.
// Revision    : 1.0
// ============================================================================
module logo_bounce_controller
    import logo_pkg::*;
#(
    parameter int LOGO_SIZE      = c_LOGO_SIZE,
    parameter int DISPLAY_WIDTH  = c_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = c_DISPLAY_HEIGHT,
    parameter int INIT_LEFT      = 200,
    parameter int INIT_TOP       = 200,
    parameter int INIT_DIR_X     = 1,
    parameter int INIT_DIR_Y     = 0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    logo_bounce_controller_if.slave bus
);

    localparam logic [9:0] c_MAX_X     = max_origin(DISPLAY_WIDTH, LOGO_SIZE);
    localparam logic [9:0] c_MAX_Y     = max_origin(DISPLAY_HEIGHT, LOGO_SIZE);
    localparam logic [9:0] c_TRIG_VPOS = 10'(DISPLAY_HEIGHT);
    localparam logic [0:0] c_ST_IDLE   = 1'(IDLE);
    localparam logic [0:0] c_ST_MOVE   = 1'(MOVE);

    logic [0:0] r_state;
    logic [1:0] r_steps_left;
    logic [9:0] r_prev_vpos;
    logic [2:0] r_color;
    logic       r_bounce;
    logic       r_corner;
    logic       w_trigger;
    logic       w_step_en;
    logic       w_flip_x;
    logic       w_flip_y;
    logic [9:0] w_left;
    logic [9:0] w_top;
    logic       w_dir_x;
    logic       w_dir_y;

    // Edge on vpos reaching the blanking line: one trigger per frame.
    assign w_trigger = (bus.vpos == c_TRIG_VPOS) && (r_prev_vpos != c_TRIG_VPOS);
    assign w_step_en = (r_state == c_ST_MOVE);

    bounce_axis #(
        .MAX      (c_MAX_X),
        .INIT_POS (10'(INIT_LEFT)),
        .INIT_DIR (1'(INIT_DIR_X))
    ) u_axis_x (
        .clk       (clk),
        .rst       (reset),
        .i_step_en (w_step_en),
        .o_pos     (w_left),
        .o_dir     (w_dir_x),
        .o_flip    (w_flip_x)
    );

    bounce_axis #(
        .MAX      (c_MAX_Y),
        .INIT_POS (10'(INIT_TOP)),
        .INIT_DIR (1'(INIT_DIR_Y))
    ) u_axis_y (
        .clk       (clk),
        .rst       (reset),
        .i_step_en (w_step_en),
        .o_pos     (w_top),
        .o_dir     (w_dir_y),
        .o_flip    (w_flip_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_steps_left <= 2'd0;
            r_prev_vpos  <= 10'd0;
            r_color      <= 3'd1;
            r_bounce     <= 1'b0;
            r_corner     <= 1'b0;
        end else begin
            r_prev_vpos <= bus.vpos;
            r_bounce    <= 1'b0;
            r_corner    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trigger && !bus.pause) begin
                        r_state      <= c_ST_MOVE;
                        r_steps_left <= bus.speed;
                    end
                end
                c_ST_MOVE: begin
                    r_bounce <= w_flip_x | w_flip_y;
                    r_corner <= w_flip_x & w_flip_y;
                    // Colour cycles 1..7, skipping 0; a corner counts once.
                    if (w_flip_x | w_flip_y) begin
                        r_color <= (r_color == 3'd7) ? 3'd1 : (r_color + 3'd1);
                    end
                    if (r_steps_left == 2'd0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_steps_left <= r_steps_left - 2'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.logo_left = w_left;
    assign bus.logo_top  = w_top;
    assign bus.dir_x     = w_dir_x;
    assign bus.dir_y     = w_dir_y;
    assign bus.color     = r_color;
    assign bus.busy      = w_step_en;
    assign bus.bounce    = r_bounce;
    assign bus.corner    = r_corner;

endmodule
`default_nettype wire

// File: tb/tb_logo_bounce_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_logo_bounce_controller
// Description : Scoreboard bench for two controller instances (default start
//               and a start one pixel off a corner) driven by shared stimulus.
// Revision    : 1.0
// ============================================================================
module tb_logo_bounce_controller;

    typedef struct {
        int left;
        int top;
        int dx;
        int dy;
        int color;
        int bnc;
        int cor;
    } exp_t;

    localparam int c_MAX_L = 512;
    localparam int c_MAX_T = 352;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;
    logic lb0 = 1'b0;
    logic lb1 = 1'b0;

    exp_t m0, m1, init0, init1;
    exp_t q0[$];
    exp_t q1[$];

    logo_bounce_controller_if bus0 ();
    logo_bounce_controller_if bus1 ();

    logo_bounce_controller u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    logo_bounce_controller #(
        .INIT_LEFT (511),
        .INIT_TOP  (1)
    ) u_corner (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic cmp_state(input string who, input exp_t e,
                             input logic [9:0] l, input logic [9:0] t,
                             input logic dx, input logic dy, input logic [2:0] c,
                             input logic b, input logic k);
        chk({who, ".logo_left"}, 32'(l),  e.left);
        chk({who, ".logo_top"},  32'(t),  e.top);
        chk({who, ".dir_x"},     32'(dx), e.dx);
        chk({who, ".dir_y"},     32'(dy), e.dy);
        chk({who, ".color"},     32'(c),  e.color);
        chk({who, ".bounce"},    32'(b),  e.bnc);
        chk({who, ".corner"},    32'(k),  e.cor);
    endtask

    // One pixel of motion on a 2-D screen: move, then reverse on touching a border.
    function automatic exp_t step(input exp_t s);
        exp_t r;
        int   fx, fy;
        r     = s;
        r.left = s.left + (s.dx != 0 ? 1 : -1);
        r.top  = s.top  + (s.dy != 0 ? 1 : -1);
        if (r.left == 0)       r.dx = 1;
        if (r.left == c_MAX_L) r.dx = 0;
        if (r.top == 0)        r.dy = 1;
        if (r.top == c_MAX_T)  r.dy = 0;
        fx    = (r.dx != s.dx) ? 1 : 0;
        fy    = (r.dy != s.dy) ? 1 : 0;
        r.bnc = (fx + fy > 0) ? 1 : 0;
        r.cor = (fx + fy == 2) ? 1 : 0;
        if (r.bnc != 0) r.color = (s.color % 7) + 1;
        return r;
    endfunction

    task automatic push_steps(input int n);
        for (int k = 0; k < n; k++) begin
            m0 = step(m0);
            q0.push_back(m0);
            m1 = step(m1);
            q1.push_back(m1);
        end
    endtask

    task automatic drive(input logic [9:0] v, input logic [1:0] s, input logic p);
        bus0.vpos = v;  bus0.speed = s;  bus0.pause = p;
        bus1.vpos = v;  bus1.speed = s;  bus1.pause = p;
    endtask

    task automatic drain_check();
        chk("dut0.scoreboard_drained", 32'(q0.size()), 32'd0);
        chk("dut1.scoreboard_drained", 32'(q1.size()), 32'd0);
    endtask

    task automatic frame(input logic [1:0] spd, input logic p, input int hold, input bit pause_rise);
        @(posedge clk); #1 drive(10'd479, $urandom_range(0, 3), $urandom_range(0, 1));
        @(posedge clk); #1 drive(10'd480, spd, p);
        if (!p) push_steps(int'(spd) + 1);
        @(posedge clk); #1;
        chk("dut0.busy_after_trigger", 32'(bus0.busy), 32'(!p));
        chk("dut1.busy_after_trigger", 32'(bus1.busy), 32'(!p));
        if (pause_rise) drive(10'd480, 2'($urandom_range(0, 3)), 1'b1);
        repeat (hold) @(posedge clk);
        #1 drive(10'd0, 2'($urandom_range(0, 3)), 1'b0);
        repeat (6) @(posedge clk);
        #1 drain_check();
    endtask

    // Reset lands on the edge ending the second MOVE cycle: one step, then reset values.
    task automatic reset_mid_move();
        @(posedge clk); #1 drive(10'd479, 2'd0, 1'b0);
        @(posedge clk); #1 drive(10'd480, 2'd3, 1'b0);
        push_steps(1);
        m0 = init0;  q0.push_back(m0);
        m1 = init1;  q1.push_back(m1);
        @(posedge clk); #1;
        chk("dut0.busy_before_reset", 32'(bus0.busy), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        drive(10'd0, 2'd0, 1'b0);
        repeat (6) @(posedge clk);
        #1 drain_check();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (lb0 === 1'b1) begin
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut0.unexpected_step: got a step result, expected none (t=%0t)", $time);
                end else begin
                    e = q0.pop_front();
                    cmp_state("dut0", e, bus0.logo_left, bus0.logo_top, bus0.dir_x, bus0.dir_y,
                              bus0.color, bus0.bounce, bus0.corner);
                end
            end else begin
                chk("dut0.bounce_idle", 32'(bus0.bounce), 32'd0);
                chk("dut0.corner_idle", 32'(bus0.corner), 32'd0);
            end
        end
        lb0 <= bus0.busy;
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (lb1 === 1'b1) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut1.unexpected_step: got a step result, expected none (t=%0t)", $time);
                end else begin
                    e = q1.pop_front();
                    cmp_state("dut1", e, bus1.logo_left, bus1.logo_top, bus1.dir_x, bus1.dir_y,
                              bus1.color, bus1.bounce, bus1.corner);
                end
            end else begin
                chk("dut1.bounce_idle", 32'(bus1.bounce), 32'd0);
                chk("dut1.corner_idle", 32'(bus1.corner), 32'd0);
            end
        end
        lb1 <= bus1.busy;
    end

    initial begin
        init0 = '{left: 200, top: 200, dx: 1, dy: 0, color: 1, bnc: 0, cor: 0};
        init1 = '{left: 511, top: 1,   dx: 1, dy: 0, color: 1, bnc: 0, cor: 0};
        m0 = init0;
        m1 = init1;
        reset = 1'b1;
        drive(10'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmp_state("dut0.reset", init0, bus0.logo_left, bus0.logo_top, bus0.dir_x, bus0.dir_y,
                  bus0.color, bus0.bounce, bus0.corner);
        cmp_state("dut1.reset", init1, bus1.logo_left, bus1.logo_top, bus1.dir_x, bus1.dir_y,
                  bus1.color, bus1.bounce, bus1.corner);
        chk("dut0.reset.busy", 32'(bus0.busy), 32'd0);
        chk("dut1.reset.busy", 32'(bus1.busy), 32'd0);
        reset   = 1'b0;
        started = 1'b1;

        frame(2'd0, 1'b0, 100, 1'b0);   // single step, vpos held at the trigger line
        frame(2'd3, 1'b0, 2, 1'b0);
        frame(2'd0, 1'b1, 2, 1'b0);     // paused frame
        frame(2'd3, 1'b0, 2, 1'b1);     // pause raised mid-move
        reset_mid_move();
        chk("dut0.after_reset.left", 32'(bus0.logo_left), 32'd200);

        for (int i = 0; i < 1500; i++) begin
            frame(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom_range(1, 4), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logo_bounce_controller.md
# logo_bounce_controller

Per-frame motion sequencer for the bouncing-logo VGA design. It watches the sync generator's vertical position and, once per frame at the start of vertical blanking, advances the logo's top-left coordinate by a programmable number of pixels. Motion is one pixel per cycle with an edge check on every pixel, so the logo never overshoots the screen border. It reverses direction at the borders, cycles a colour index on every bounce, and flags corner hits. Its position and colour outputs drive the logo renderer and ROM addressing in the top level.

## Interface
Parameters:
- LOGO_SIZE, 128: logo edge length in pixels.
- DISPLAY_WIDTH, 640: visible width.
- DISPLAY_HEIGHT, 480: visible height; also the vpos value that triggers an update.
- INIT_LEFT, 200: reset value of logo_left; must satisfy 0 < INIT_LEFT < DISPLAY_WIDTH-LOGO_SIZE.
- INIT_TOP, 200: reset value of logo_top; must satisfy 0 < INIT_TOP < DISPLAY_HEIGHT-LOGO_SIZE.
- INIT_DIR_X, 1: reset dir_x (1 = rightward).
- INIT_DIR_Y, 0: reset dir_y (1 = downward).

Ports:
- clk  in  1  pixel clock; the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- vpos  in  10  vertical position from vga_sync_generator.
- speed  in  2  pixels moved per frame, minus 1 (0 gives 1 px, 3 gives 4 px); sampled at trigger.
- pause  in  1  while high at trigger, the frame's update is skipped.
- logo_left  out  10  logo x origin, registered.
- logo_top  out  10  logo y origin, registered.
- dir_x  out  1  current x direction.
- dir_y  out  1  current y direction.
- color  out  3  colour index, range 1..7 (never 0).
- busy  out  1  high while in MOVE.
- bounce  out  1  one-cycle pulse on any direction flip.
- corner  out  1  one-cycle pulse when both axes flip in the same step.

## Operation
- Constants: MAX_LEFT = DISPLAY_WIDTH-LOGO_SIZE (512 at defaults) and MAX_TOP = DISPLAY_HEIGHT-LOGO_SIZE (352 at defaults).
- Trigger detection: prev_vpos is registered every cycle. trigger = (vpos == DISPLAY_HEIGHT) && (prev_vpos != DISPLAY_HEIGHT).
  - trigger therefore fires exactly once per frame, however long vpos stays at DISPLAY_HEIGHT.
- FSM states:
  - IDLE → MOVE when trigger && !pause. On this transition, steps_left <= speed.
  - IDLE → IDLE when trigger && pause.
  - MOVE: performs one step per cycle. → IDLE when steps_left == 0, otherwise steps_left decrements.
- Triggers that arrive during MOVE are ignored. This cannot occur in normal use.
- pause and speed changes during MOVE have no effect; the current frame completes.
- Step per axis, with the x axis shown; the y axis is identical using logo_top, dir_y and MAX_TOP:
  - nx = logo_left + 1 if dir_x is 1, else logo_left − 1, computed at 10 bits.
  - logo_left <= nx.
  - If nx == 0, dir_x <= 1. If nx == MAX_LEFT, dir_x <= 0.
  - flip_x is true when dir_x changes in this step.
- Per step outputs:
  - bounce <= flip_x | flip_y.
  - corner <= flip_x & flip_y.
  - If bounce, color <= (color == 7) ? 1 : color + 1. A corner advances the colour once, not twice.
- Values stay within 0..MAX, so wrap-around cannot occur when the INIT constraints hold.
- Reset values: logo_left=INIT_LEFT, logo_top=INIT_TOP, dir_x=INIT_DIR_X, dir_y=INIT_DIR_Y, color=1, busy=0, bounce=0, corner=0, state=IDLE, steps_left=0, prev_vpos=0.
- Reset asserted mid-MOVE restores all reset values on the next edge. Any partial frame motion is discarded.

## Timing
- Cycle T is the first cycle with vpos == DISPLAY_HEIGHT. At edge T+1 the state is MOVE and busy=1.
- The first step result is visible after edge T+2. Step k is visible after edge T+1+k.
- busy=1 for exactly speed+1 cycles. The step with steps_left == 0 returns the state to IDLE on the same edge.
- bounce, corner and color update on the same edge as the step that caused them.
- All updates complete within 5 cycles inside vertical blanking, so there is no visible tearing.

## Structure
- Shared package logo_pkg holds:
  - LOGO_SIZE, DISPLAY_WIDTH, DISPLAY_HEIGHT.
  - Derived MAX_LEFT and MAX_TOP.
  - State enum {IDLE, MOVE}.
- Sub-module bounce_axis holds one position register, its direction register, the bound compare and the flip output. It has parameters MAX, INIT_POS and INIT_DIR, and an input step_en. It is instantiated once for x and once for y.
- The top of the block holds trigger detection, the FSM, steps_left, colour and pulse logic.

## Test plan
- Reset with defaults → logo_left=200, logo_top=200, dir_x=1, dir_y=0, color=1, busy=bounce=corner=0.
- speed=0, vpos stepped 479→480 → busy high for 1 cycle; left=201, top=199; no bounce. Holding vpos at 480 for 100 cycles → no further change.
- speed=3 → busy high for 4 cycles. Left goes 201, 202, 203, 204 on successive edges and top goes 199, 198, 197, 196.
- INIT_LEFT=510, speed=3 → left goes 511, 512, 511, 510; dir_x=0 after the 512 step; bounce pulses once; color goes 1→2.
- INIT_LEFT=511, INIT_TOP=1, speed=0 → left=512, top=0, dir_x=0, dir_y=1; bounce=corner=1 for one cycle; color=2. With the colour preset at 7 by repeated bounces, the next bounce gives color=1.
- pause=1 at trigger → positions unchanged and busy stays 0. pause rising during a speed=3 MOVE → all 4 steps still occur. reset asserted in the 2nd MOVE cycle → reset values on the next edge.
